// File: rtl/bfs_dst_write_arbiter_pkg.sv
// Shared sizing and the per-lane FIFO entry layout for the BFS destination
// write arbiter.
package bfs_dst_write_arbiter_pkg;

  localparam int LANE_NUM           = 4;
  localparam int DST_ID_DWIDTH      = 16;
  localparam int MASK_WIDTH         = 16;
  localparam int VERTEX_BRAM_DWIDTH = 32;
  localparam int FIFO_DEPTH         = 8;
  localparam int AF_MARGIN          = 2;

  typedef struct packed {
    logic [DST_ID_DWIDTH-1:0]      dst_id;
    logic [MASK_WIDTH-1:0]         mask;
    logic [VERTEX_BRAM_DWIDTH-1:0] data;
  } lane_entry_t;

  localparam int ENTRY_W = $bits(lane_entry_t);

endpackage

// File: rtl/bfs_dst_write_arbiter_lane_fifo.sv
// Per-lane synchronous FIFO; a push into a full FIFO is taken only when the
// same cycle also pops.
module bfs_lane_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (rd_en) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage needs no reset: the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/bfs_dst_write_arbiter.sv
// Buffers four lanes of BFS level updates and round-robins them onto the
// single vertex-BRAM write port through a valid/ready output register.
module bfs_dst_write_arbiter
  import bfs_dst_write_arbiter_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [LANE_NUM*DST_ID_DWIDTH-1:0]      in_dst_id,
  input  logic [LANE_NUM*MASK_WIDTH-1:0]         in_mask,
  input  logic [LANE_NUM*VERTEX_BRAM_DWIDTH-1:0] in_data,
  input  logic [LANE_NUM-1:0]                    in_valid,
  output logic [LANE_NUM-1:0]                    lane_af,
  output logic [DST_ID_DWIDTH-1:0]               wr_addr,
  output logic [MASK_WIDTH-1:0]                  wr_mask,
  output logic [VERTEX_BRAM_DWIDTH-1:0]          wr_data,
  output logic                                   wr_valid,
  input  logic                                   wr_ready,
  input  logic                                   clr_ovf,
  output logic [LANE_NUM-1:0]                    ovf,
  output logic [31:0]                            wr_count,
  output logic                                   idle
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(LANE_NUM);

  logic [LANE_NUM-1:0]          push, pop, full, empty, ovf_set;
  logic [LANE_NUM-1:0][CW-1:0]  count;
  lane_entry_t [LANE_NUM-1:0]   head;
  logic [PW-1:0]                rr_q, rr_d, grant;
  logic                         any_ne, load_en;
  lane_entry_t                  out_q, out_d;
  logic                         wr_valid_q, wr_valid_d;
  logic [LANE_NUM-1:0]          ovf_q, ovf_d, af_q, af_d;
  logic [31:0]                  cnt_q, cnt_d;

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    lane_entry_t din;
    assign din = {in_dst_id[i*DST_ID_DWIDTH +: DST_ID_DWIDTH],
                  in_mask[i*MASK_WIDTH +: MASK_WIDTH],
                  in_data[i*VERTEX_BRAM_DWIDTH +: VERTEX_BRAM_DWIDTH]};
    // An all-zero mask writes nothing, so it is never buffered.
    assign push[i] = in_valid[i] && (|in_mask[i*MASK_WIDTH +: MASK_WIDTH]);

    bfs_lane_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   (din),
      .dout_o  (head[i]),
      .count_o (count[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Scan downward so the lane closest to rr_q is the last (winning) match.
  always_comb begin
    grant  = rr_q;
    any_ne = 1'b0;
    for (int k = LANE_NUM - 1; k >= 0; k--) begin
      if (!empty[rr_q + PW'(k)]) begin
        grant  = rr_q + PW'(k);
        any_ne = 1'b1;
      end
    end
  end

  assign load_en = !wr_valid_q || wr_ready;
  assign ovf_set = push & full & ~pop;

  always_comb begin
    pop        = '0;
    rr_d       = rr_q;
    out_d      = out_q;
    wr_valid_d = wr_valid_q;
    if (load_en) begin
      wr_valid_d = any_ne;
      if (any_ne) begin
        pop[grant] = 1'b1;
        out_d      = head[grant];
        rr_d       = grant + 1'b1;
      end
    end
    cnt_d = cnt_q + 32'(wr_valid_q && wr_ready);
    ovf_d = (ovf_q & ~{LANE_NUM{clr_ovf}}) | ovf_set;
    for (int i = 0; i < LANE_NUM; i++) begin
      af_d[i] = (count[i] >= CW'(FIFO_DEPTH - AF_MARGIN));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      out_q      <= '0;
      wr_valid_q <= 1'b0;
      ovf_q      <= '0;
      af_q       <= '0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      out_q      <= out_d;
      wr_valid_q <= wr_valid_d;
      ovf_q      <= ovf_d;
      af_q       <= af_d;
      cnt_q      <= cnt_d;
    end
  end

  assign wr_addr  = out_q.dst_id;
  assign wr_mask  = out_q.mask;
  assign wr_data  = out_q.data;
  assign wr_valid = wr_valid_q;
  assign ovf      = ovf_q;
  assign lane_af  = af_q;
  assign wr_count = cnt_q;
  assign idle     = (&empty) && !wr_valid_q;

endmodule

// File: tb/tb_bfs_dst_write_arbiter.sv
// Self-checking bench: per-lane expected-write queues checked by a write
// monitor, a vector table for single pushes, and directed multi-cycle cases.
module tb_bfs_dst_write_arbiter;
  import bfs_dst_write_arbiter_pkg::*;

  logic                                   clk = 1'b0;
  logic                                   rst;
  logic [LANE_NUM*DST_ID_DWIDTH-1:0]      in_dst_id;
  logic [LANE_NUM*MASK_WIDTH-1:0]         in_mask;
  logic [LANE_NUM*VERTEX_BRAM_DWIDTH-1:0] in_data;
  logic [LANE_NUM-1:0]                    in_valid;
  logic [LANE_NUM-1:0]                    lane_af;
  logic [DST_ID_DWIDTH-1:0]               wr_addr;
  logic [MASK_WIDTH-1:0]                  wr_mask;
  logic [VERTEX_BRAM_DWIDTH-1:0]          wr_data;
  logic                                   wr_valid;
  logic                                   wr_ready;
  logic                                   clr_ovf;
  logic [LANE_NUM-1:0]                    ovf;
  logic [31:0]                            wr_count;
  logic                                   idle;

  bfs_dst_write_arbiter dut (
    .clk(clk), .rst(rst), .in_dst_id(in_dst_id), .in_mask(in_mask),
    .in_data(in_data), .in_valid(in_valid), .lane_af(lane_af),
    .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .clr_ovf(clr_ovf),
    .ovf(ovf), .wr_count(wr_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          exp_cnt = 0;
  lane_entry_t expq [LANE_NUM][$];

  typedef struct {
    int          lane;
    logic [15:0] id;
    logic [15:0] mask;
    logic [27:0] data;
    int          exp_wr;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Lane number rides in data[31:28] so the monitor knows which queue to pop.
  task automatic set_lane(input int l, input logic [15:0] id, input logic [15:0] m,
                          input logic [27:0] d, input bit acc);
    lane_entry_t e;
    e = {id, m, {4'(l), d}};
    in_valid[l] = 1'b1;
    in_dst_id[l*DST_ID_DWIDTH +: DST_ID_DWIDTH] = id;
    in_mask[l*MASK_WIDTH +: MASK_WIDTH] = m;
    in_data[l*VERTEX_BRAM_DWIDTH +: VERTEX_BRAM_DWIDTH] = {4'(l), d};
    if (acc && m != 16'h0) expq[l].push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int l;
    lane_entry_t e;
    if (!rst && wr_valid && wr_ready) begin
      l = int'(wr_data[29:28]);
      if (expq[l].size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", wr_addr, wr_data);
      end else begin
        e = expq[l].pop_front();
        check("wr_entry", {wr_addr, wr_mask, wr_data}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_dst_id = '0; in_mask = '0; in_data = '0; in_valid = '0;
    wr_ready = 1'b1; clr_ovf = 1'b0;
    vt[0] = '{1, 16'h0100, 16'h0000, 28'h1, 0};
    vt[1] = '{1, 16'h0101, 16'h0001, 28'h2, 1};
    vt[2] = '{3, 16'hFFFF, 16'h8000, 28'hFFFFFFF, 1};
    vt[3] = '{2, 16'h0000, 16'hFFFF, 28'h0, 1};
    vt[4] = '{0, 16'h0200, 16'h0000, 28'h5, 0};
    vt[5] = '{3, 16'h0300, 16'h00F0, 28'h7, 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", {wr_addr, wr_mask, wr_data}, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_ovf", ovf, 0);
    check("rst_lane_af", lane_af, 0);
    check("rst_idle", idle, 1);

    // All four lanes at once, twice: rr_ptr must be back at 0 after each round.
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 16'(10 + 10*r + i), 16'hFFFF, 28'(i), 1);
      step();
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("rr_valid", wr_valid, 1);
        check("rr_order", wr_addr, 64'(10 + 10*r + i));
      end
      @(negedge clk);
      exp_cnt += 4;
      check("rr_done_valid", wr_valid, 0);
      check("rr_wr_count", wr_count, 64'(exp_cnt));
      @(posedge clk); #1;
    end

    // Single-lane latency: presented in cycle N, visible on the write port at N+2.
    set_lane(0, 16'd5, 16'hFFFF, 28'd3, 1);
    @(negedge clk);
    check("lat_n0_valid", wr_valid, 0);
    step();
    @(negedge clk);
    check("lat_n1_valid", wr_valid, 0);
    check("lat_n1_idle", idle, 0);
    @(negedge clk);
    check("lat_n2_valid", wr_valid, 1);
    check("lat_n2_addr", wr_addr, 5);
    check("lat_n2_data", wr_data, 3);
    @(negedge clk);
    exp_cnt += 1;
    check("lat_wr_count", wr_count, 64'(exp_cnt));
    check("lat_idle", idle, 1);
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      set_lane(vt[v].lane, vt[v].id, vt[v].mask, vt[v].data, 1);
      step();
      cyc(3);
      @(negedge clk);
      exp_cnt += vt[v].exp_wr;
      check("vec_wr_count", wr_count, 64'(exp_cnt));
      check("vec_ovf", ovf, 0);
      check("vec_idle", idle, 1);
      @(posedge clk); #1;
    end

    // Backpressure: rr_ptr is 0 here, so lane 0's entry is the one held.
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_lane(i, 16'(16'h500 + i), 16'hFFFF, 28'(28'h500 + i), 1);
    step();
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", wr_valid, 1);
      check("bp_addr", wr_addr, 16'h500);
      check("bp_data", wr_data, 32'h0000_0500);
    end
    check("bp_wr_count", wr_count, 64'(exp_cnt));
    @(posedge clk); #1 wr_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_drain_valid", wr_valid, 1);
    end
    @(negedge clk);
    exp_cnt += 3;
    check("bp_drain_done", wr_valid, 0);
    check("bp_drain_count", wr_count, 64'(exp_cnt));

    // Overflow: lane 0 occupies the stalled output, then lane 2 gets 10 pushes.
    @(posedge clk); #1 wr_ready = 1'b0;
    set_lane(0, 16'h600, 16'hFFFF, 28'h600, 1);
    step();
    for (int k = 0; k < 10; k++) begin
      set_lane(2, 16'(16'h700 + k), 16'hFFFF, 28'(k), k < 8);
      step();
      if (k == 5) check("af_before", lane_af[2], 0);
      if (k == 6) check("af_rise", lane_af[2], 1);
    end
    @(negedge clk);
    check("ovf_set", ovf, 4'b0100);
    check("ovf_af_held", lane_af, 4'b0100);
    @(posedge clk); #1 wr_ready = 1'b1;
    cyc(12);
    exp_cnt += 9;
    check("ovf_drain_count", wr_count, 64'(exp_cnt));
    check("ovf_af_clear", lane_af, 0);
    check("ovf_sb_empty", 64'(expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()), 0);
    check("ovf_sticky", ovf, 4'b0100);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", ovf, 0);

    // Async reset while four entries are pending and the port is stalled.
    @(posedge clk); #1 wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 16'(16'h800 + i), 16'hFFFF, 28'h800, 1);
    step();
    cyc(1);
    check("pre_rst_valid", wr_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", wr_valid, 0);
    check("arst_out", {wr_addr, wr_mask, wr_data}, 0);
    check("arst_count", wr_count, 0);
    check("arst_idle", idle, 1);
    for (int i = 0; i < 4; i++) expq[i].delete();
    @(posedge clk); #1 rst = 1'b0; wr_ready = 1'b1;
    cyc(6);
    check("post_rst_count", wr_count, 0);
    check("post_rst_idle", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bfs_dst_write_arbiter.md
Name: bfs_dst_write_arbiter

Overview:
- Collects per-lane destination updates from the four vertex lanes of the BFS edge-process stage: dst_id, src_p_mask_r and the computed level.
- Buffers each lane in a small FIFO and round-robin arbitrates them onto the single vertex-BRAM write port.
- Sits between the edge-process outputs and the vertex BRAM write side.
- Raises per-lane almost-full stall flags toward the upstream scheduler, because the edge pipeline has no ready input.

Parameters:
- LANE_NUM, 4, number of vertex lanes (fixed at 4 for this revision).
- DST_ID_DWIDTH, `DST_ID_DWIDTH (nominal 16), destination address width.
- MASK_WIDTH, `MASK_WIDTH (nominal 16), byte/word write mask width.
- VERTEX_BRAM_DWIDTH, `VERTEX_BRAM_DWIDTH (nominal 32), level data width.
- FIFO_DEPTH, 8, entries per lane FIFO (power of 2).
- AF_MARGIN, 2, almost-full asserted when count >= FIFO_DEPTH - AF_MARGIN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_dst_id  in  LANE_NUM*DST_ID_DWIDTH  per-lane destination id; lane i occupies slice i.
- in_mask  in  LANE_NUM*MASK_WIDTH  per-lane src_p_mask_r.
- in_data  in  LANE_NUM*VERTEX_BRAM_DWIDTH  per-lane level value.
- in_valid  in  LANE_NUM  per-lane valid.
- lane_af  out  LANE_NUM  per-lane almost-full stall request.
- wr_addr  out  DST_ID_DWIDTH  BRAM write address.
- wr_mask  out  MASK_WIDTH  BRAM write mask.
- wr_data  out  VERTEX_BRAM_DWIDTH  BRAM write data.
- wr_valid  out  1  write request.
- wr_ready  in  1  BRAM port accepts the request.
- clr_ovf  in  1  synchronous clear of the overflow flags.
- ovf  out  LANE_NUM  sticky per-lane overflow.
- wr_count  out  32  number of completed writes (wraps at 2^32).
- idle  out  1  all FIFOs empty and wr_valid low.

Behaviour:
- Reset (asynchronous, active-high): all FIFOs empty, rr_ptr=0, wr_valid=0, wr_addr/wr_mask/wr_data=0, ovf=0, wr_count=0, lane_af=0, idle=1. Reset mid-transfer drops all buffered entries and any pending output without completing them.
- Push:
  - A lane pushes when in_valid[i]=1 and in_mask slice != 0.
  - valid with mask==0 is dropped silently and counts neither as a write nor as an overflow.
- Full FIFO:
  - A push is accepted if a pop from the same lane occurs in that cycle.
  - Otherwise the push is discarded and ovf[i] is set.
  - ovf is sticky until clr_ovf or rst; if a new overflow coincides with clr_ovf, set wins.
- Almost-full: lane_af[i] is registered from count >= FIFO_DEPTH-AF_MARGIN and updates one cycle after the count changes.
- Output register (single stage, valid/ready):
  - load_en = !wr_valid || wr_ready.
  - When load_en is high and any FIFO is non-empty, grant the first non-empty lane scanning rr_ptr, rr_ptr+1, ... mod LANE_NUM.
  - The grant pops that lane's head into wr_addr/wr_mask/wr_data, sets wr_valid=1 and sets rr_ptr=grant+1 mod LANE_NUM.
  - When load_en is high and all FIFOs are empty, wr_valid goes to 0.
  - While wr_valid=1 and wr_ready=0, wr_addr/wr_mask/wr_data are held stable and nothing pops.
- Throughput: one write per cycle with wr_ready held high.
- Latency: input at cycle N, with empty FIFOs and the lane winning, gives wr_valid at cycle N+2 (FIFO write at N+1, output load at N+2).
- Ordering: FIFO order within a lane is preserved. Across lanes there is no ordering guarantee. No address merging is done (BFS level writes are idempotent).
- wr_count increments on each cycle with wr_valid && wr_ready.
- idle is combinational: all counts zero && !wr_valid.

Decomposition:
- Shared package/header: LANE_NUM, FIFO_DEPTH, AF_MARGIN, and the per-lane entry packing {dst_id, mask, data} with its width constant.
- One sub-module, bfs_lane_fifo:
  - Synchronous FIFO with push/pop/count/full/empty.
  - Simultaneous push+pop when full is allowed.
  - Instantiated LANE_NUM times.
- The round-robin grant and the output register stay in the top module.

Test Plan:
- Single lane: in_valid=4'b0001, dst_id=5, mask=16'hFFFF, data=3 at cycle 10, wr_ready=1 -> wr_valid at cycle 12 with addr 5, data 3; wr_count=1; idle=1 afterwards.
- Four lanes valid in the same cycle (ids 10, 11, 12, 13), rr_ptr=0, wr_ready=1 -> writes in order 10, 11, 12, 13 on consecutive cycles; rr_ptr ends at 0.
- Backpressure: 3 entries queued, wr_ready=0 for 5 cycles -> wr_addr/wr_data stable and wr_valid high throughout; after release, 3 writes complete in 3 cycles.
- Overflow: lane 2 pushed 10 times back-to-back with wr_ready=0 -> lane_af[2] rises after the 6th push; 8 entries kept; ovf[2]=1; wr_count reaches 8 after drain; clr_ovf clears ovf[2].
- Mask zero: in_valid=1 with mask=0 on lane 1 -> no FIFO push, no write, ovf unchanged.
- Async reset asserted mid-drain with 4 entries pending -> outputs return to reset values immediately, without waiting for a clk edge; no further writes after deassert.
